log2_pq_pipe: RTL and testbench

Pipelined, parametrised piecewise-quadratic base-2 logarithm unit for unsigned integer operands. It normalises the operand with a leading-one search and takes the integer part of the result from the leading-one position. The fractional part is evaluated as c − a·x² + b·x from a run-time-loadable coefficient RAM indexed by the top mantissa bits. It sits in the arithmetic datapath behind valid/ready producers and replaces the fixed-table, unclocked 6-bit-index evaluator with a streaming, configurable one.

---
 rtl/log2_pq_pipe.sv | 174 +++++++++++++++++
 tb/tb_log2_pq_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_pq_pipe.sv
// Streaming base-2 logarithm: leading-one normalisation gives the integer part,
// and a piecewise-quadratic fit c - a*x^2 + b*x from a loadable table gives the fraction.
module log2_pq_pipe #(
    parameter int IN_W     = 32,
    parameter int Y_W      = 6,
    parameter int X_W      = 17,
    parameter int A_W      = 14,
    parameter int B_W      = 38,
    parameter int C_W      = 41,
    parameter int C_FR     = 40,
    parameter int OUT_FRAC = 23,
    parameter int IW       = $clog2(IN_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW+OUT_FRAC-1:0] out_z,
    output logic                   out_err,
    input  logic                   cfg_we,
    input  logic [Y_W-1:0]         cfg_addr,
    input  logic [A_W-1:0]         cfg_a,
    input  logic [B_W-1:0]         cfg_b,
    input  logic [C_W-1:0]         cfg_c
);
    localparam int M_W   = Y_W + X_W;
    localparam int DEPTH = 1 << Y_W;
    localparam int XSQ_W = 2 * X_W;
    localparam int BX_W  = B_W + X_W;
    localparam int AX_W  = A_W + XSQ_W;
    localparam int ACC_W = C_W + 2 * X_W + 2;
    localparam int SH    = 2 * X_W + C_FR - OUT_FRAC;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SH - 1);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Normalise: shift the leading one just above the mantissa field and keep the bits below it.
    logic [IW-1:0]  lead_pos;
    logic [IW-1:0]  norm_sh;
    logic [M_W-1:0] mant;
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_x[i]) lead_pos = IW'(i);
        end
        norm_sh = IW'(IN_W - 1) - lead_pos;
        mant    = M_W'(({in_x, {M_W{1'b0}}} << norm_sh) >> (IN_W - 1));
    end

    logic           v1, err1;
    logic [IW-1:0]  p1;
    logic [Y_W-1:0] idx1;
    logic [X_W-1:0] xf1;
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            err1 <= (in_x == '0);
            p1   <= lead_pos;
            idx1 <= mant[M_W-1:X_W];
            xf1  <= mant[X_W-1:0];
        end
    end

    // Coefficient table: written regardless of pipeline state, never cleared.
    logic [A_W-1:0] ram_a [DEPTH];
    logic [B_W-1:0] ram_b [DEPTH];
    logic [C_W-1:0] ram_c [DEPTH];
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            ram_a[cfg_addr] <= cfg_a;
            ram_b[cfg_addr] <= cfg_b;
            ram_c[cfg_addr] <= cfg_c;
        end
    end

    logic             v2, err2;
    logic [IW-1:0]    p2;
    logic [X_W-1:0]   x2;
    logic [XSQ_W-1:0] xsq2;
    logic [A_W-1:0]   a2;
    logic [B_W-1:0]   b2;
    logic [C_W-1:0]   c2;
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2   <= v1;
            err2 <= err1;
            p2   <= p1;
            x2   <= xf1;
            xsq2 <= xf1 * xf1;
            a2   <= ram_a[idx1];
            b2   <= ram_b[idx1];
            c2   <= ram_c[idx1];
        end
    end

    logic            v3, err3;
    logic [IW-1:0]   p3;
    logic [C_W-1:0]  c3;
    logic [BX_W-1:0] bx3;
    logic [AX_W-1:0] ax3;
    always_ff @(posedge clk) begin
        if (rst) begin
            v3 <= 1'b0;
        end else if (adv) begin
            v3   <= v2;
            err3 <= err2;
            p3   <= p2;
            c3   <= c2;
            bx3  <= b2 * x2;
            ax3  <= a2 * xsq2;
        end
    end

    // Align all three terms on 2^(2*X_W) scaling before the signed sum.
    logic [ACC_W-1:0]        c_term, bx_term, ax_term;
    logic signed [ACC_W-1:0] acc_nxt;
    always_comb begin
        c_term  = ACC_W'({c3, {XSQ_W{1'b0}}});
        bx_term = ACC_W'({bx3, {X_W{1'b0}}});
        ax_term = ACC_W'(ax3);
        acc_nxt = $signed(c_term) + $signed(bx_term) - $signed(ax_term);
    end

    logic                    v4, err4;
    logic [IW-1:0]           p4;
    logic signed [ACC_W-1:0] acc4;
    always_ff @(posedge clk) begin
        if (rst) begin
            v4 <= 1'b0;
        end else if (adv) begin
            v4   <= v3;
            err4 <= err3;
            p4   <= p3;
            acc4 <= acc_nxt;
        end
    end

    // Round to nearest, clamp negatives to zero and overflow to all-ones.
    // A non-negative acc plus HALF cannot carry out of ACC_W bits.
    logic [ACC_W-1:0]    rnd, rnd_q;
    logic [OUT_FRAC-1:0] frac;
    always_comb begin
        rnd   = $unsigned(acc4) + HALF;
        rnd_q = rnd >> SH;
        if (acc4[ACC_W-1])
            frac = '0;
        else if (|rnd_q[ACC_W-1:OUT_FRAC])
            frac = '1;
        else
            frac = rnd_q[OUT_FRAC-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= v4;
            out_err   <= v4 && err4;
            out_z     <= err4 ? '0 : {p4, frac};
        end
    end

endmodule

// File: tb/tb_log2_pq_pipe.sv
// Scoreboard bench for log2_pq_pipe: driver pushes expected results on acceptance,
// an independent monitor pops and compares on every output transfer.
module tb_log2_pq_pipe;
    localparam int Z_W = 28;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_x;
    logic           out_valid;
    logic           out_ready;
    logic [Z_W-1:0] out_z;
    logic           out_err;
    logic           cfg_we;
    logic [5:0]     cfg_addr;
    logic [13:0]    cfg_a;
    logic [37:0]    cfg_b;
    logic [40:0]    cfg_c;

    always #5 clk = ~clk;

    log2_pq_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c)
    );

    typedef struct {
        logic [Z_W-1:0] z;
        logic           err;
        int             acc_cyc;
        bit             chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b0;
    logic [13:0] mod_a [64];
    logic [37:0] mod_b [64];
    logic [40:0] mod_c [64];

    bit          pend_we = 1'b0;
    bit          pend_rst = 1'b0;
    logic [5:0]  pend_addr = '0;
    logic [13:0] pend_a = '0;
    logic [37:0] pend_b = '0;
    logic [40:0] pend_c = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: log2 from the leading-one position plus the quadratic fit in wide arithmetic.
    function automatic void model(input logic [31:0] v, output logic [Z_W-1:0] z, output logic e);
        int p;
        logic [63:0] m, idx, xv;
        logic signed [95:0] ca, cb, caa, xs, acc, r;
        logic [22:0] f;
        z = '0;
        e = 1'b0;
        if (v == 0) begin
            e = 1'b1;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        m   = ((64'(v) << 23) >> p) & ((64'd1 << 23) - 64'd1);
        idx = m >> 17;
        xv  = m & 64'h1FFFF;
        ca  = 96'(mod_c[idx[5:0]]);
        cb  = 96'(mod_b[idx[5:0]]);
        caa = 96'(mod_a[idx[5:0]]);
        xs  = 96'(xv);
        acc = ca * (96'sd1 <<< 34) + cb * xs * (96'sd1 <<< 17) - caa * xs * xs;
        if (acc < 0) begin
            f = '0;
        end else begin
            r = (acc + (96'sd1 <<< 50)) >>> 51;
            f = (r >= 96'sd8388608) ? 23'h7FFFFF : r[22:0];
        end
        z = {p[4:0], f};
    endfunction

    // One clock of stimulus; a pending table write takes effect at this edge.
    task automatic step(input bit v, input logic [31:0] x, input bit ordy,
                        input bit lit, input logic [Z_W-1:0] lz, input bit le, output bit acc);
        bit   rdy;
        exp_t e;
        @(negedge clk);
        #1;
        rst       = pend_rst;
        in_valid  = v;
        in_x      = x;
        out_ready = ordy;
        cfg_we    = pend_we;
        cfg_addr  = pend_addr;
        cfg_a     = pend_a;
        cfg_b     = pend_b;
        cfg_c     = pend_c;
        #1;
        rdy       = in_ready;
        e.acc_cyc = cyc + 1;
        @(posedge clk);
        if (pend_we) begin
            mod_a[pend_addr] = pend_a;
            mod_b[pend_addr] = pend_b;
            mod_c[pend_addr] = pend_c;
        end
        pend_we = 1'b0;
        acc = v && rdy && !pend_rst;
        if (acc) begin
            if (lit) begin
                e.z   = lz;
                e.err = le;
            end else begin
                model(x, e.z, e.err);
            end
            e.chk_lat = lat_mode;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(1'b0, 32'h0, ordy, 1'b0, '0, 1'b0, a);
    endtask

    task automatic send_lit(input logic [31:0] x, input logic [Z_W-1:0] lz, input bit le);
        bit a;
        step(1'b1, x, 1'b1, 1'b1, lz, le, a);
        check("accepted", 64'(a), 64'd1);
    endtask

    task automatic set_cfg(input logic [5:0] ad, input logic [13:0] a,
                           input logic [37:0] b, input logic [40:0] c);
        pend_we   = 1'b1;
        pend_addr = ad;
        pend_a    = a;
        pend_b    = b;
        pend_c    = c;
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 9) == 0) return 32'h0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    // Monitor: compares on each output transfer and checks stall behaviour.
    bit             prev_stall = 1'b0;
    logic [Z_W-1:0] prev_z;
    logic           prev_err;
    exp_t           got;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_z", 64'(out_z), 64'(prev_z));
                    check("stall_hold_err", 64'(out_err), 64'(prev_err));
                    check("stall_hold_valid", 64'(out_valid), 64'd1);
                end
                if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0h required=none", out_z);
                    end else begin
                        got = sb.pop_front();
                        check("out_z", 64'(out_z), 64'(got.z));
                        check("out_err", 64'(out_err), 64'(got.err));
                        if (got.chk_lat) check("latency", 64'(cyc - got.acc_cyc), 64'd4);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_z     = out_z;
                prev_err   = out_err;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit          a;
        int          sent;
        int          n;
        logic [31:0] x;
        bit          have;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_z", 64'(out_z), 64'd0);
        check("reset_out_err", 64'(out_err), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < 64; k++) begin
            set_cfg(6'(k), '0, '0, '0);
            idle(1'b1);
        end

        // Integer part with an all-zero table, exact latency
        lat_mode = 1'b1;
        send_lit(32'h0000_0001, {5'd0, 23'h0}, 1'b0);
        send_lit(32'h8000_0000, {5'd31, 23'h0}, 1'b0);
        send_lit(32'h0001_2345, {5'd16, 23'h0}, 1'b0);
        repeat (6) idle(1'b1);

        // Lookup, rounding, saturation and negative clamp on entry 32
        set_cfg(6'd32, '0, '0, 41'd1 << 39);
        idle(1'b1);
        send_lit(32'h3, {5'd1, 23'h400000}, 1'b0);
        set_cfg(6'd32, '0, '0, 41'd1 << 40);
        idle(1'b1);
        send_lit(32'h3, {5'd1, 23'h7FFFFF}, 1'b0);
        set_cfg(6'd32, 14'h3FFF, '0, '0);
        idle(1'b1);
        send_lit(32'hC000_0100, {5'd31, 23'h0}, 1'b0);
        send_lit(32'h0, '0, 1'b1);
        send_lit(32'h2, {5'd1, 23'h0}, 1'b0);
        repeat (6) idle(1'b1);

        // Config race: the item reading entry 32 at the write edge sees old data
        set_cfg(6'd32, '0, '0, 41'd1 << 39);
        idle(1'b1);
        send_lit(32'h3, {5'd1, 23'h400000}, 1'b0);
        set_cfg(6'd32, '0, '0, 41'd1 << 38);
        send_lit(32'h3, {5'd1, 23'h200000}, 1'b0);
        repeat (6) idle(1'b1);

        // Reset with three items in flight
        for (int k = 0; k < 3; k++) send_lit(32'h10 << k, {5'(4 + k), 23'h0}, 1'b0);
        pend_rst = 1'b1;
        idle(1'b1);
        sb.delete();
        pend_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            #1;
            check("no_stale_valid", 64'(out_valid), 64'd0);
        end

        // Random table for the streaming phases
        for (int k = 0; k < 64; k++) begin
            set_cfg(6'(k), 14'($urandom), 38'({$urandom, $urandom}),
                    41'({$urandom, $urandom}) >> $urandom_range(0, 4));
            idle(1'b1);
        end

        // Backpressure: 8 operands with a 3-cycle stall mid-stream
        lat_mode = 1'b0;
        sent = 0;
        have = 1'b0;
        x = '0;
        for (int k = 0; k < 60 && sent < 8; k++) begin
            if (!have) begin
                x = rand_operand();
                have = 1'b1;
            end
            step(1'b1, x, !(k >= 5 && k < 8), 1'b0, '0, 1'b0, a);
            if (a) begin
                sent++;
                have = 1'b0;
            end
        end
        check("bp_sent", 64'(sent), 64'd8);
        repeat (8) idle(1'b1);

        // Random valid/ready streaming
        have = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!have) begin
                x = rand_operand();
                have = 1'b1;
            end
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0, 1'b0, '0, 1'b0, a);
            if (a) have = 1'b0;
        end

        n = 0;
        while (sb.size() != 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
